// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32 instruction fetch stage with prefetch FIFO and redirect flush
// Ports:
//   clk, rst                          core clock; asynchronous active-low reset
//   imem_req, imem_addr, imem_gnt     in-order word fetch requests to instruction memory
//   imem_rvalid, imem_rdata           in-order responses, at least one cycle after grant
//   redirect_valid, redirect_pc       taken branch/jump pulse and its target
//   id_valid, id_pc, id_instr         head of the prefetch FIFO presented to decode
//   id_ready                          decode consumes the head this cycle
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam int          CW1     = CW + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_out, r_drop, r_count;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr, r_pcq_rd, r_pcq_wr;
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_pcq        [FIFO_DEPTH];

  logic          w_redirect, w_gnt, w_pop, w_push, w_id_valid;
  logic [CW:0]   w_inflight, w_drop_calc;
  logic [CW-1:0] w_drop_nxt;
  logic          w_unused_bits;

  // Buffered plus in-flight words never exceed the FIFO, so a push always finds room.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_out};
  assign imem_req   = (r_state == S_FETCH) && (w_inflight < DEPTH_W);
  assign imem_addr  = r_pc;

  assign w_redirect = redirect_valid && (r_state != S_IDLE);
  assign w_gnt      = imem_req && imem_gnt;
  assign w_id_valid = (r_count != '0);
  assign w_pop      = w_id_valid && id_ready;
  // A response arriving with a redirect belongs to the abandoned path.
  assign w_push     = imem_rvalid && !w_redirect && (r_drop == '0) && (r_state == S_FETCH);

  assign id_valid = w_id_valid;
  assign id_pc    = w_id_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
  assign id_instr = w_id_valid ? r_fifo_instr[r_rd_ptr] : NOP;

  // Everything still owed by memory after a redirect must be swallowed:
  // pending drops, live requests, a grant landing now, less a response landing now.
  assign w_drop_calc = {1'b0, r_drop} + {1'b0, r_out} + CW1'(w_gnt) - CW1'(imem_rvalid);

  assign w_unused_bits = ^{redirect_pc[1:0], w_drop_calc[CW]};

  always_comb begin
    w_drop_nxt = r_drop;
    if (w_redirect) begin
      w_drop_nxt = w_drop_calc[CW-1:0];
    end else if (imem_rvalid && (r_drop != '0)) begin
      w_drop_nxt = r_drop - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (w_redirect && (w_drop_nxt != '0)) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_redirect) begin
          w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_FETCH;
        end else if (r_drop == '0) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_pcq_rd <= '0;
      r_pcq_wr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_redirect) begin
        // Any same-cycle pop is implicitly honoured: the whole FIFO is emptied.
        r_pc     <= {redirect_pc[31:2], 2'b00};
        r_out    <= '0;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_pcq_rd <= '0;
        r_pcq_wr <= '0;
      end else begin
        if (w_gnt) begin
          r_pc     <= r_pc + 32'd4;
          r_pcq_wr <= r_pcq_wr + PW'(1);
        end
        if (w_push) begin
          r_pcq_rd <= r_pcq_rd + PW'(1);
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_out   <= r_out + CW'(w_gnt) - CW'(w_push);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage only; validity is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (w_gnt && !w_redirect) begin
      r_pcq[r_pcq_wr] <= r_pc;
    end
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;

  logic        w_req, w_idv;
  logic [31:0] w_addr, w_idpc, w_idinstr;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_idv), .id_pc(w_idpc), .id_instr(w_idinstr), .id_ready(1'b0)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       memq[$];
  exp_t        sb[$];
  mreq_t       bk_m;
  exp_t        bk_e, mon_e;
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, since_rst = 0, stale = 0;
  logic [31:0] exp_pc = RST_PC;
  int          gnt_pct, rdy_pct, rsp_pct, lat_max;
  bit          hold_rsp, rnd_redir, hit;
  int          first;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic chk_reset_outputs();
    check("rst_imem_req", imem_req == 1'b0, {31'b0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr == RST_PC, imem_addr, RST_PC);
    check("rst_id_valid", id_valid == 1'b0, {31'b0, id_valid}, 32'h0);
    check("rst_id_pc", id_pc == 32'h0, id_pc, 32'h0);
    check("rst_id_instr", id_instr == NOP, id_instr, NOP);
  endtask

  // Memory and decode stimulus for one cycle, applied at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    since_rst++;
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    id_ready       = ($urandom_range(99) < rdy_pct);
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (!hold_rsp && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(memq[0].addr);
      void'(memq.pop_front());
      if (stale > 0) stale--;
    end
    if (rnd_redir && since_rst > 2 && $urandom_range(99) < 4) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom & 32'h0000_FFFF;
    end
  endtask

  // Issue side of the reference model: expected fetch PC sequence and delivered stream.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      if (stale > 0) check("drain_no_req", !imem_req, {31'b0, imem_req}, 32'h0);
      if (imem_req && imem_gnt) begin
        check("fetch_addr", imem_addr == exp_pc, imem_addr, exp_pc);
        bk_m.addr = imem_addr;
        bk_m.due  = cyc + int'($urandom_range(lat_max, 1));
        memq.push_back(bk_m);
        if (!redirect_valid) begin
          bk_e.pc    = exp_pc;
          bk_e.instr = mem_data(exp_pc);
          sb.push_back(bk_e);
          check("inflight_bound", sb.size() <= DEPTH, sb.size(), DEPTH);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        stale  = memq.size();
      end
    end
  end

  // Decode-side monitor.
  always begin
    @(negedge clk);
    #1;
    if (rst && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        check("id_unexpected", 1'b0, id_pc, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("id_pc", id_pc == mon_e.pc, id_pc, mon_e.pc);
        check("id_instr", id_instr == mon_e.instr, id_instr, mon_e.instr);
      end
    end
  end

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    gnt_pct = 100; rdy_pct = 100; rsp_pct = 100; lat_max = 1;
    hold_rsp = 1'b0; rnd_redir = 1'b0;

    step(); step(); #1;
    chk_reset_outputs();
    step(); rst = 1'b1; since_rst = 0;

    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step(); #1;
      if (k == 1) check("wrap_addr_first", w_req && w_addr == 32'hFFFF_FFFC, w_addr, 32'hFFFF_FFFC);
      if (k == 2) check("wrap_addr_next", w_req && w_addr == 32'h0, w_addr, 32'h0);
      if (id_valid && first < 0) first = k;
    end
    check("first_id_latency", first == 3, first, 3);

    rdy_pct = 0;
    repeat (8) step();
    #1;
    check("stall_req_low", !imem_req, {31'b0, imem_req}, 32'h0);
    check("stall_head_valid", id_valid, {31'b0, id_valid}, 32'h1);
    rdy_pct = 100;
    repeat (4) step();

    hold_rsp = 1'b1;
    repeat (6) step();
    #1;
    check("inflight_full_idle", !imem_req && !id_valid, {30'b0, imem_req, id_valid}, 32'h0);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    repeat (3) step();
    #1;
    check("drain_req_low", !imem_req, {31'b0, imem_req}, 32'h0);
    hold_rsp = 1'b0;
    repeat (12) step();

    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      step();
      if (imem_rvalid && id_valid) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; hit = 1'b1;
      end
    end
    check("coincident_setup", hit, {31'b0, hit}, 32'h1);
    repeat (10) step();

    hold_rsp = 1'b1;
    repeat (4) step();
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step(); #1;
    check("pre_reset_drain", !imem_req, {31'b0, imem_req}, 32'h0);
    #2; rst = 1'b0; #1;
    chk_reset_outputs();
    memq.delete(); sb.delete(); stale = 0; exp_pc = RST_PC; hold_rsp = 1'b0;
    step(); step(); rst = 1'b1; since_rst = 0;

    gnt_pct = 70; rdy_pct = 70; rsp_pct = 75; lat_max = 4; rnd_redir = 1'b1;
    repeat (3000) step();
    rnd_redir = 1'b0; gnt_pct = 0; rdy_pct = 100; rsp_pct = 100;
    repeat (40) step();
    #1;
    check("final_drain", sb.size() == 0, sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
